// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes common to the control decoder and the
// instruction encoder, the encoder's field-kind enum and its FSM state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_SW  = 7'd35;
    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_BEQ = 7'd99;

    typedef enum logic [1:0] {
        KIND_LW  = 2'd0,
        KIND_SW  = 2'd1,
        KIND_R   = 2'd2,
        KIND_BEQ = 2'd3
    } kind_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/instr_fifo.sv
// Two-entry in-order FIFO holding {instruction, word address} pairs.
// Pointers and occupancy reset asynchronously; storage is left unreset.
module instr_fifo #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign full   = (r_cnt == 2'd2);
    assign empty  = (r_cnt == 2'd0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) r_wr <= ~r_wr;
            if (w_pop)  r_rd <= ~r_rd;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder (lw/sw/R-type/beq) streaming words plus addresses
// into imem. Optional field checking enabled by the INSTR_ENC_CHECK_EN macro.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ADDR_BASE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [12:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_BASE[ADDR_W-1:0];

    function automatic logic [31:0] encode(
        input kind_e       kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [12:0] imm
    );
        logic [31:0] w;
        case (kind)
            KIND_LW:  w = {imm[11:0], rs1, 3'b010, rd, OP_LW};
            KIND_SW:  w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
            KIND_R:   w = {f7, rs2, rs1, f3, rd, OP_R};
            default:  w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BEQ};
        endcase
        return w;
    endfunction

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                w_start;
    logic                w_accept;
    logic                w_bad;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [31:0]         w_word;
    logic [ADDR_W+31:0]  w_head;

    assign w_start  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign in_ready = (r_state == ST_RUN) && !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && !w_bad;
    assign w_pop    = out_ready && !w_empty;
    assign w_word   = encode(kind_e'(in_kind), in_rd, in_rs1, in_rs2,
                             in_funct3, in_funct7, in_imm);

`ifdef INSTR_ENC_CHECK_EN
    logic r_err;

    always_comb begin
        w_bad = 1'b0;
        case (kind_e'(in_kind))
            KIND_LW:  w_bad = (in_imm[12] != in_imm[11]) || (in_rd == 5'd0);
            KIND_SW:  w_bad = (in_imm[12] != in_imm[11]);
            KIND_R:   w_bad = (in_rd == 5'd0);
            default:  w_bad = in_imm[0];
        endcase
    end

    // Sticky until the next session starts; dropped bundles never reach the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                r_err <= 1'b0;
        else if (w_start)            r_err <= 1'b0;
        else if (w_accept && w_bad)  r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign w_bad = 1'b0;
    assign err   = 1'b0;
`endif

    instr_fifo #(.W(ADDR_W + 32)) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({w_word, r_addr}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign out_valid = !w_empty;
    assign out_instr = w_empty ? 32'd0 : w_head[ADDR_W+31:ADDR_W];
    assign out_addr  = w_empty ? r_addr : w_head[ADDR_W-1:0];
    assign done      = (r_state == ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (w_start) r_state <= ST_RUN;
                ST_RUN:           if (w_accept && in_last) r_state <= ST_DRAIN;
                default:          if (w_empty) r_state <= ST_DONE;
            endcase
        end
    end

    // Counter wraps silently at 2^ADDR_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_addr <= BASE;
        else if (w_start) r_addr <= BASE;
        else if (w_push)  r_addr <= r_addr + 1'b1;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default instance plus a narrow-address
// instance (ADDR_W=2, ADDR_BASE=3) driven in lockstep from the same inputs.
module tb_instr_encoder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [12:0] in_imm;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  out_valid,  done,  err;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        in_ready2, out_valid2, done2, err2;
    logic [31:0] out_instr2;
    logic [1:0]  out_addr2;

    logic [39:0] q1[$];
    logic [33:0] q2[$];

    int n_vec = 0;
    int n_err = 0;

    instr_encoder u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .done(done), .err(err)
    );

    instr_encoder #(.ADDR_W(2), .ADDR_BASE(3)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready2), .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_instr(out_instr2), .out_addr(out_addr2),
        .done(done2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && out_valid && out_ready)   q1.push_back({out_instr, out_addr});
        if (reset_n && out_valid2 && out_ready)  q2.push_back({out_instr2, out_addr2});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] k, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                        input logic [4:0] a_rs2, input logic [2:0] a_f3, input logic [6:0] a_f7,
                        input logic [12:0] a_imm, input logic last);
        bit got;
        in_kind = k; in_rd = a_rd; in_rs1 = a_rs1; in_rs2 = a_rs2;
        in_funct3 = a_f3; in_funct7 = a_f7; in_imm = a_imm; in_last = last;
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                got = 1'b1;
                step();
                break;
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL send_handshake got in_ready=0 for 50 cycles want accept");
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            step();
        end
        n_vec++;
        if (done !== 1'b1 || done2 !== 1'b1) begin
            n_err++;
            $display("FAIL done got %b/%b want 1/1", done, done2);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_kind = 2'd0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        step(); step();
        n_vec++; if (in_ready !== 1'b0)    begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0)   begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_vec++; if (out_instr !== 32'd0)  begin n_err++; $display("FAIL rst_out_instr got %h want 0", out_instr); end
        n_vec++; if (out_addr !== 8'd0)    begin n_err++; $display("FAIL rst_out_addr got %h want 0", out_addr); end
        n_vec++; if (out_addr2 !== 2'd3)   begin n_err++; $display("FAIL rst_out_addr2 got %h want 3", out_addr2); end
        n_vec++; if (done !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL rst_done_err got %b%b want 00", done, err); end
        reset_n = 1'b1;
        step();
        n_vec++; if (in_ready !== 1'b0)    begin n_err++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
    endtask

    task automatic test_single_lw();
        out_ready = 1'b1;
        pulse_start();
        n_vec++; if (in_ready !== 1'b1)    begin n_err++; $display("FAIL run_in_ready got %b want 1", in_ready); end
        q1.delete(); q2.delete();
        send(2'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 13'd8, 1'b1);
        n_vec++; if (out_valid !== 1'b1)   begin n_err++; $display("FAIL lw_valid got %b want 1", out_valid); end
        n_vec++; if (out_instr !== 32'h00812283) begin n_err++; $display("FAIL lw_word got %h want 00812283", out_instr); end
        n_vec++; if (out_addr !== 8'd0)    begin n_err++; $display("FAIL lw_addr got %h want 0", out_addr); end
        n_vec++; if (in_ready !== 1'b0)    begin n_err++; $display("FAIL drain_in_ready got %b want 0", in_ready); end
        wait_done();
        n_vec++; if (q1.size() != 1)       begin n_err++; $display("FAIL lw_count got %0d want 1", q1.size()); end
    endtask

    task automatic test_stream();
        pulse_start();
        n_vec++; if (done !== 1'b0)        begin n_err++; $display("FAIL restart_done got %b want 0", done); end
        q1.delete(); q2.delete();
        send(2'd1, 5'd0, 5'd3, 5'd6, 3'd0, 7'd0, 13'd12, 1'b0);
        send(2'd2, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 13'd0, 1'b0);
        send(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC, 1'b1);
        wait_done();
        n_vec++; if (q1.size() != 3 || q2.size() != 3) begin n_err++; $display("FAIL stream_count got %0d/%0d want 3/3", q1.size(), q2.size()); end
        n_vec++; if (q1[0] !== {32'h0061A623, 8'd0}) begin n_err++; $display("FAIL sw_word got %h want 0061a62300", q1[0]); end
        n_vec++; if (q1[1] !== {32'h003100B3, 8'd1}) begin n_err++; $display("FAIL add_word got %h want 003100b301", q1[1]); end
        n_vec++; if (q1[2] !== {32'hFE208EE3, 8'd2}) begin n_err++; $display("FAIL beq_word got %h want fe208ee302", q1[2]); end
        n_vec++; if (q2[0][1:0] !== 2'd3 || q2[1][1:0] !== 2'd0 || q2[2][1:0] !== 2'd1) begin
            n_err++; $display("FAIL wrap_addr got %0d,%0d,%0d want 3,0,1", q2[0][1:0], q2[1][1:0], q2[2][1:0]);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        pulse_start();
        q1.delete(); q2.delete();
        send(2'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 13'd8, 1'b0);
        send(2'd1, 5'd0, 5'd3, 5'd6, 3'd0, 7'd0, 13'd12, 1'b0);
        in_kind = 2'd2; in_rd = 5'd7; in_rs1 = 5'd4; in_rs2 = 5'd5;
        in_funct3 = 3'd0; in_funct7 = 7'h20; in_imm = '0; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
            n_vec++; if (out_instr !== 32'h00812283 || out_valid !== 1'b1) begin
                n_err++; $display("FAIL head_stable got %h/%b want 00812283/1", out_instr, out_valid);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b0)    begin n_err++; $display("FAIL no_passthru got %b want 0", in_ready); end
        send(2'd2, 5'd7, 5'd4, 5'd5, 3'd0, 7'h20, 13'd0, 1'b1);
        wait_done();
        n_vec++; if (q1.size() != 3)       begin n_err++; $display("FAIL bp_count got %0d want 3", q1.size()); end
        n_vec++; if (q1[0] !== {32'h00812283, 8'd0} || q1[1] !== {32'h0061A623, 8'd1} || q1[2] !== {32'h405203B3, 8'd2}) begin
            n_err++; $display("FAIL bp_order got %h %h %h want 0081228300 0061a62301 405203b302", q1[0], q1[1], q1[2]);
        end
    endtask

    task automatic test_check();
        out_ready = 1'b1;
        pulse_start();
        q1.delete(); q2.delete();
        send(2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd3, 1'b0);
        send(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd4, 1'b1);
        wait_done();
`ifdef INSTR_ENC_CHECK_EN
        n_vec++; if (q1.size() != 1)       begin n_err++; $display("FAIL chk_count got %0d want 1", q1.size()); end
        n_vec++; if (q1[0] !== {32'h00402083, 8'd0}) begin n_err++; $display("FAIL chk_lw got %h want 0040208300", q1[0]); end
        n_vec++; if (q2[0][1:0] !== 2'd3)  begin n_err++; $display("FAIL chk_lw_addr2 got %0d want 3", q2[0][1:0]); end
        n_vec++; if (err !== 1'b1 || err2 !== 1'b1) begin n_err++; $display("FAIL chk_err got %b/%b want 1/1", err, err2); end
`else
        n_vec++; if (q1.size() != 2)       begin n_err++; $display("FAIL chk_count got %0d want 2", q1.size()); end
        n_vec++; if (q1[0] !== {32'h00000163, 8'd0}) begin n_err++; $display("FAIL chk_beq got %h want 0000016300", q1[0]); end
        n_vec++; if (q1[1] !== {32'h00402083, 8'd1}) begin n_err++; $display("FAIL chk_lw got %h want 0040208301", q1[1]); end
        n_vec++; if (err !== 1'b0 || err2 !== 1'b0) begin n_err++; $display("FAIL chk_err got %b/%b want 0/0", err, err2); end
`endif
        pulse_start();
        n_vec++; if (err !== 1'b0)         begin n_err++; $display("FAIL err_clear got %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        q1.delete(); q2.delete();
        send(2'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 13'd8, 1'b0);
        send(2'd1, 5'd0, 5'd3, 5'd6, 3'd0, 7'd0, 13'd12, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b/%b want 0/0", out_valid, out_valid2); end
        n_vec++; if (in_ready !== 1'b0)    begin n_err++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
        step();
        reset_n = 1'b1;
        step();
        n_vec++; if (in_ready !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL post_rst_idle got %b%b want 00", in_ready, done); end
        n_vec++; if (out_addr !== 8'd0 || out_addr2 !== 2'd3) begin n_err++; $display("FAIL post_rst_addr got %h/%h want 0/3", out_addr, out_addr2); end
        out_ready = 1'b1;
        step(); step(); step();
        n_vec++; if (q1.size() != 0 || out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_emit got %0d words want 0", q1.size()); end
    endtask

    initial begin
        test_reset();
        test_single_lw();
        test_stream();
        test_back_to_back();
        test_check();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
